// File: rtl/serial_adder_sub_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
interface serial_adder_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    modport master (output start, A, B, Cin, Sub, input busy, done, S, Cout, Ovf);
    modport slave  (input start, A, B, Cin, Sub, output busy, done, S, Cout, Ovf);
endinterface

// File: rtl/serial_adder_sub.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple chain,
// carry held in a flop between steps, start/busy/done handshake.
module serial_adder_sub #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_sub_if.slave  bus
);
    localparam int unsigned STEPS = WIDTH / DIGIT;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [DIGIT-1:0] sum_c;
    logic             carry_out_c;
    logic             msb_cin_c;

    // Ripple of DIGIT full-adder cells on the low digit of the operand registers
    always_comb begin : digit_add
        logic c;
        c         = carry_q;
        sum_c     = '0;
        msb_cin_c = 1'b0;
        for (int i = 0; i < int'(DIGIT); i++) begin
            msb_cin_c = c;
            sum_c[i]  = a_q[i] ^ b_q[i] ^ c;
            c         = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
        end
        carry_out_c = c;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = WIDTH'({sum_c, acc_q} >> DIGIT);
                carry_d = carry_out_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(STEPS - 1)) begin
                    state_d = DONE;
                    s_d     = WIDTH'({sum_c, acc_q} >> DIGIT);
                    cout_d  = carry_out_c;
                    // last step's top cell is bit WIDTH-1
                    ovf_d   = msb_cin_c ^ carry_out_c;
                end
            end
            default: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.A;
                    b_d     = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Cin ^ bus.Sub;
                    cnt_d   = '0;
                    acc_d   = '0;
                    s_d     = '0;
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.Ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_sub.sv
// Bench for serial_adder_sub: five width/digit configurations checked each
// cycle against an arithmetic reference, plus directed literal cases.
module tb_serial_adder_sub;
    localparam int NL = 5;

    function automatic int cfg_w(input int i);
        return (i < 3) ? 8 : 16;
    endfunction

    function automatic int cfg_d(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            3:       return 4;
            default: return 16;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    logic        start_drv [NL];
    logic [15:0] a_drv [NL];
    logic [15:0] b_drv [NL];
    logic        cin_drv [NL];
    logic        sub_drv [NL];

    wire        busy_o [NL];
    wire        done_o [NL];
    wire [15:0] s_o [NL];
    wire        cout_o [NL];
    wire        ovf_o [NL];

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int unsigned W = cfg_w(g);
        localparam int unsigned D = cfg_d(g);
        serial_adder_sub_if #(.WIDTH(W)) bus ();
        serial_adder_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.start = start_drv[g];
        assign bus.A     = W'(a_drv[g]);
        assign bus.B     = W'(b_drv[g]);
        assign bus.Cin   = cin_drv[g];
        assign bus.Sub   = sub_drv[g];
        assign busy_o[g] = bus.busy;
        assign done_o[g] = bus.done;
        assign s_o[g]    = 16'(bus.S);
        assign cout_o[g] = bus.Cout;
        assign ovf_o[g]  = bus.Ovf;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result {Ovf, Cout, S} from plain integer arithmetic
    function automatic logic [17:0] model_op(input int w, input logic [15:0] a_in,
                                             input logic [15:0] b_in, input logic cin,
                                             input logic sub);
        longint m, half, a, b, c, r, sa, sb, sr;
        logic   co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        a    = longint'(a_in) & m;
        b    = longint'(b_in) & m;
        c    = longint'(cin);
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        if (sub) begin
            r  = a - b - c;
            co = (r >= 0);
            sr = sa - sb - c;
        end else begin
            r  = a + b + c;
            co = (r > m);
            sr = sa + sb + c;
        end
        ov = (sr >= half) || (sr < -half);
        return {ov, co, 16'(r & m)};
    endfunction

    // Timeline model: cycles remaining in the current operation and held results
    int          rem [NL];
    logic        exp_done [NL];
    logic [15:0] es [NL];
    logic        ec [NL];
    logic        ev [NL];
    logic [17:0] pend [NL];
    int          done_cnt [NL];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < NL; l++) begin
                rem[l]      <= 0;
                exp_done[l] <= 1'b0;
                es[l]       <= '0;
                ec[l]       <= 1'b0;
                ev[l]       <= 1'b0;
                pend[l]     <= '0;
            end
        end else begin
            for (int l = 0; l < NL; l++) begin
                exp_done[l] <= (rem[l] == 1);
                if (rem[l] == 1) begin
                    es[l] <= pend[l][15:0];
                    ec[l] <= pend[l][16];
                    ev[l] <= pend[l][17];
                end
                if (rem[l] != 0) begin
                    rem[l] <= rem[l] - 1;
                end else if (start_drv[l]) begin
                    rem[l]  <= cfg_w(l) / cfg_d(l);
                    pend[l] <= model_op(cfg_w(l), a_drv[l], b_drv[l], cin_drv[l], sub_drv[l]);
                    es[l]   <= '0;
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int l = 0; l < NL; l++)
            if (done_o[l]) done_cnt[l] <= done_cnt[l] + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < NL; l++) begin
                check($sformatf("lane%0d busy", l), 32'(busy_o[l]), 32'(rem[l] != 0));
                check($sformatf("lane%0d done", l), 32'(done_o[l]), 32'(exp_done[l]));
                check($sformatf("lane%0d S", l), 32'(s_o[l]), 32'(es[l]));
                if (rem[l] == 0) begin
                    check($sformatf("lane%0d Cout", l), 32'(cout_o[l]), 32'(ec[l]));
                    check($sformatf("lane%0d Ovf", l), 32'(ovf_o[l]), 32'(ev[l]));
                end
            end
        end
    end

    // Issue one op from a negedge; returns at the negedge where done is seen
    task automatic run_op(input int l, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] xs,
                          input logic xc, input logic xv, input int xlat, input bit pulse);
        int k;
        int bc;
        k  = 0;
        bc = 0;
        a_drv[l] = a; b_drv[l] = b; cin_drv[l] = cin; sub_drv[l] = sub;
        start_drv[l] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_drv[l] = 1'b0;
        a_drv[l] = 16'($urandom); b_drv[l] = 16'($urandom);
        cin_drv[l] = 1'($urandom); sub_drv[l] = 1'($urandom);
        while (!done_o[l] && k < 64) begin
            if (busy_o[l]) bc++;
            if (pulse && k == 2) begin
                start_drv[l] = 1'b1; a_drv[l] = 16'h00AA; b_drv[l] = 16'h0055;
            end
            if (pulse && k == 3) start_drv[l] = 1'b0;
            @(negedge clk);
            k++;
        end
        check($sformatf("lane%0d latency a=%0h b=%0h", l, a, b), 32'(k), 32'(xlat));
        check($sformatf("lane%0d busy cycles", l), 32'(bc), 32'(xlat));
        check($sformatf("lane%0d lit S a=%0h b=%0h", l, a, b), 32'(s_o[l]), 32'(xs));
        check($sformatf("lane%0d lit Cout a=%0h b=%0h", l, a, b), 32'(cout_o[l]), 32'(xc));
        check($sformatf("lane%0d lit Ovf a=%0h b=%0h", l, a, b), 32'(ovf_o[l]), 32'(xv));
    endtask

    task automatic wait_done(input int l, output longint t);
        int k;
        k = 0;
        while (!done_o[l] && k < 64) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("lane%0d done seen", l), 32'(done_o[l]), 32'd1);
        t = cyc;
    endtask

    initial begin
        longint t1, t2;
        int     n0;
        int     base [NL];
        int     guard;
        bit     all_done;

        for (int l = 0; l < NL; l++) begin
            start_drv[l] = 1'b0; a_drv[l] = '0; b_drv[l] = '0;
            cin_drv[l] = 1'b0; sub_drv[l] = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        for (int l = 0; l < NL; l++) begin
            check($sformatf("lane%0d reset busy", l), 32'(busy_o[l]), 32'd0);
            check($sformatf("lane%0d reset done", l), 32'(done_o[l]), 32'd0);
            check($sformatf("lane%0d reset S", l), 32'(s_o[l]), 32'd0);
            check($sformatf("lane%0d reset Cout", l), 32'(cout_o[l]), 32'd0);
            check($sformatf("lane%0d reset Ovf", l), 32'(ovf_o[l]), 32'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8, 1'b0);
        run_op(0, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 8, 1'b1);
        n0 = done_cnt[0];
        repeat (12) @(negedge clk);
        check("lane0 no extra done after RUN start pulse", 32'(done_cnt[0] - n0), 32'd1);
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0, 8, 1'b0);
        run_op(2, 16'h003C, 16'h004B, 1'b1, 1'b0, 16'h0088, 1'b0, 1'b1, 2, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        a_drv[0] = 16'h0010; b_drv[0] = 16'h0020; cin_drv[0] = 1'b0; sub_drv[0] = 1'b0;
        start_drv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_drv[0] = 16'h0080; b_drv[0] = 16'h0080;
        wait_done(0, t1);
        check("b2b first S", 32'(s_o[0]), 32'h30);
        check("b2b first Cout", 32'(cout_o[0]), 32'd0);
        check("b2b first Ovf", 32'(ovf_o[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        a_drv[0] = 16'($urandom); b_drv[0] = 16'($urandom); start_drv[0] = 1'b0;
        wait_done(0, t2);
        check("b2b second S", 32'(s_o[0]), 32'h00);
        check("b2b second Cout", 32'(cout_o[0]), 32'd1);
        check("b2b second Ovf", 32'(ovf_o[0]), 32'd1);
        check("b2b done spacing", 32'(t2 - t1), 32'd9);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        a_drv[0] = 16'h0055; b_drv[0] = 16'h000F; start_drv[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_drv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy_o[0]), 32'd0);
        check("abort done", 32'(done_o[0]), 32'd0);
        check("abort S", 32'(s_o[0]), 32'd0);
        check("abort Cout", 32'(cout_o[0]), 32'd0);
        check("abort Ovf", 32'(ovf_o[0]), 32'd0);
        n0 = done_cnt[0];
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort no done pulse", 32'(done_cnt[0] - n0), 32'd0);
        run_op(0, 16'h0012, 16'h0034, 1'b1, 1'b1, 16'h00DD, 1'b0, 1'b0, 8, 1'b0);

        // Random operations on lanes 0,1,3,4 until each has 1000 results
        for (int l = 0; l < NL; l++) base[l] = done_cnt[l];
        guard = 0;
        all_done = 1'b0;
        while (!all_done && guard < 20000) begin
            @(negedge clk);
            guard++;
            for (int l = 0; l < NL; l++) begin
                if (l != 2) begin
                    start_drv[l] = ($urandom_range(0, 7) != 0);
                    a_drv[l] = 16'($urandom); b_drv[l] = 16'($urandom);
                    cin_drv[l] = 1'($urandom); sub_drv[l] = 1'($urandom);
                end
            end
            all_done = 1'b1;
            for (int l = 0; l < NL; l++)
                if (l != 2 && done_cnt[l] - base[l] < 1000) all_done = 1'b0;
        end
        for (int l = 0; l < NL; l++) start_drv[l] = 1'b0;
        for (int l = 0; l < NL; l++)
            if (l != 2)
                check($sformatf("lane%0d random results reached", l),
                      32'(done_cnt[l] - base[l] >= 1000), 32'd1);
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
